// File: rtl/writeback_unit.sv
// Final pipeline stage: retires ALU results and formatted loads into the register file,
// tracking one outstanding load with an optional response timeout.
module writeback_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wr_enable,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        pending_valid,
  output logic [4:0]  pending_rd,
  output logic        load_err
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam bit                   TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  logic [4:0]           ld_rd;
  logic [2:0]           ld_funct3;
  logic [1:0]           ld_addr_lo;
  logic                 ld_reg_write;

  logic                 accept_c;
  logic                 load_ok_c;
  logic [TIMEOUT_W-1:0] cnt_inc_c;
  logic [31:0]          load_data_c;

  // Extract and extend the addressed byte/half/word from a little-endian word.
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept_c    = ex_valid & ex_ready;
  assign cnt_inc_c   = cnt + TIMEOUT_W'(1);
  assign load_data_c = fmt_load(ld_funct3, ld_addr_lo, mem_rdata);

  // Legal load type with natural alignment for its access size.
  always_comb begin
    load_ok_c = 1'b0;
    case (ex_funct3)
      3'b000, 3'b100: load_ok_c = 1'b1;
      3'b001, 3'b101: load_ok_c = !ex_addr_lo[0];
      3'b010:         load_ok_c = (ex_addr_lo == 2'b00);
      default:        load_ok_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ld_rd         <= '0;
      ld_funct3     <= '0;
      ld_addr_lo    <= '0;
      ld_reg_write  <= 1'b0;
      ex_ready      <= 1'b1;
      wr_enable     <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      pending_valid <= 1'b0;
      pending_rd    <= '0;
      load_err      <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (!ex_is_load) begin
              if (ex_reg_write && (ex_rd != 5'd0)) begin
                wr_enable <= 1'b1;
                wr_addr   <= ex_rd;
                wr_data   <= ex_result;
              end
            end else if (!load_ok_c) begin
              load_err <= 1'b1;
            end else begin
              state         <= WAIT_MEM;
              cnt           <= '0;
              ld_rd         <= ex_rd;
              ld_funct3     <= ex_funct3;
              ld_addr_lo    <= ex_addr_lo;
              ld_reg_write  <= ex_reg_write;
              ex_ready      <= 1'b0;
              pending_valid <= 1'b1;
              pending_rd    <= ex_rd;
            end
          end
        end
        WAIT_MEM: begin
          // A response arriving on the timeout cycle still completes the load.
          if (mem_rvalid) begin
            if (ld_reg_write && (ld_rd != 5'd0)) begin
              wr_enable <= 1'b1;
              wr_addr   <= ld_rd;
              wr_data   <= load_data_c;
            end
            state         <= IDLE;
            ex_ready      <= 1'b1;
            pending_valid <= 1'b0;
            pending_rd    <= '0;
          end else if (TIMEOUT_EN && (cnt_inc_c == TIMEOUT_LIMIT)) begin
            load_err      <= 1'b1;
            state         <= IDLE;
            ex_ready      <= 1'b1;
            pending_valid <= 1'b0;
            pending_rd    <= '0;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        default: begin
          state         <= IDLE;
          ex_ready      <= 1'b1;
          pending_valid <= 1'b0;
          pending_rd    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized self-checking bench for writeback_unit against a transaction-level reference.
module tb_writeback_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pending_valid;
  logic [4:0]  pending_rd;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  writeback_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result),
    .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending_valid(pending_valid), .pending_rd(pending_rd),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loaded value derived directly from the load-type rules.
  function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] d);
    logic [31:0] bv;
    logic [31:0] hv;
    bv = (d >> (8 * off)) & 32'hFF;
    hv = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0:       return (bv >= 32'd128)   ? (bv | 32'hFFFFFF00) : bv;
      1:       return (hv >= 32'd32768) ? (hv | 32'hFFFF0000) : hv;
      2:       return d;
      4:       return bv;
      5:       return hv;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input int f3, input int off);
    if (!(f3 inside {0, 1, 2, 4, 5})) return 1'b0;
    return (off % (1 << (f3 % 4))) == 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"}, 32'(ex_ready), 32'd1);
    check({tag, "_pv"},  32'(pending_valid), 32'd0);
    check({tag, "_prd"}, 32'(pending_rd), 32'd0);
  endtask

  task automatic idle_step(input bit stray);
    ex_valid   = 1'b0;
    mem_rvalid = stray;
    mem_rdata  = $urandom;
    step();
    mem_rvalid = 1'b0;
    check("idle_wen", 32'(wr_enable), 32'd0);
    check("idle_err", 32'(load_err), 32'd0);
    check_idle_outputs("idle");
  endtask

  task automatic alu_txn(input logic [4:0] rd, input logic [31:0] res, input logic rw);
    bit exp_wen;
    exp_wen = rw && (rd != 0);
    check("alu_rdy_pre", 32'(ex_ready), 32'd1);
    ex_valid     = 1'b1;
    ex_is_load   = 1'b0;
    ex_reg_write = rw;
    ex_rd        = rd;
    ex_result    = res;
    ex_funct3    = 3'($urandom);
    ex_addr_lo   = 2'($urandom);
    mem_rvalid   = ($urandom_range(0, 3) == 0);
    mem_rdata    = $urandom;
    step();
    mem_rvalid = 1'b0;
    check("alu_wen", 32'(wr_enable), 32'(exp_wen));
    if (exp_wen) begin
      check("alu_addr", 32'(wr_addr), 32'(rd));
      check("alu_data", wr_data, res);
    end
    check("alu_err", 32'(load_err), 32'd0);
    check_idle_outputs("alu");
  endtask

  // lat: wait cycles before the response; negative means the response never comes.
  task automatic load_txn(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                          input logic rw, input logic [31:0] rdata, input int lat);
    bit legal;
    legal = ref_legal(int'(f3), int'(off));
    check("ld_rdy_pre", 32'(ex_ready), 32'd1);
    ex_valid     = 1'b1;
    ex_is_load   = 1'b1;
    ex_reg_write = rw;
    ex_rd        = rd;
    ex_result    = $urandom;
    ex_funct3    = f3;
    ex_addr_lo   = off;
    mem_rvalid   = 1'b0;
    step();
    ex_valid   = 1'b0;
    ex_rd      = 5'($urandom);
    ex_funct3  = 3'($urandom);
    ex_addr_lo = 2'($urandom);
    if (!legal) begin
      check("bad_err", 32'(load_err), 32'd1);
      check("bad_wen", 32'(wr_enable), 32'd0);
      check_idle_outputs("bad");
      idle_step(1'b0);
      return;
    end
    check("ld_pv", 32'(pending_valid), 32'd1);
    check("ld_prd", 32'(pending_rd), 32'(rd));
    check("ld_rdy", 32'(ex_ready), 32'd0);
    check("ld_wen0", 32'(wr_enable), 32'd0);
    for (int i = 1; i <= TO; i++) begin
      bit rv;
      rv = (lat >= 0) && (i == lat + 1);
      mem_rvalid = rv;
      mem_rdata  = rv ? rdata : $urandom;
      step();
      mem_rvalid = 1'b0;
      if (rv) begin
        check("ld_wen", 32'(wr_enable), 32'(rw && (rd != 0)));
        if (rw && (rd != 0)) begin
          check("ld_addr", 32'(wr_addr), 32'(rd));
          check("ld_data", wr_data, ref_load(int'(f3), int'(off), rdata));
        end
        check("ld_err", 32'(load_err), 32'd0);
        check_idle_outputs("ld_done");
        return;
      end else if (i == TO) begin
        check("to_err", 32'(load_err), 32'd1);
        check("to_wen", 32'(wr_enable), 32'd0);
        check_idle_outputs("to");
        return;
      end else begin
        check("wait_pv", 32'(pending_valid), 32'd1);
        check("wait_prd", 32'(pending_rd), 32'(rd));
        check("wait_rdy", 32'(ex_ready), 32'd0);
        check("wait_wen", 32'(wr_enable), 32'd0);
        check("wait_err", 32'(load_err), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    ex_valid     = 1'b0;
    ex_reg_write = 1'b0;
    ex_is_load   = 1'b0;
    ex_rd        = '0;
    ex_result    = '0;
    ex_funct3    = '0;
    ex_addr_lo   = '0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    step();
    step();
    check("rst_wen", 32'(wr_enable), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check_idle_outputs("rst");
    reset_n = 1'b1;

    // Directed scenarios.
    alu_txn(5'd5, 32'hDEADBEEF, 1'b1);
    idle_step(1'b0);
    load_txn(5'd7,  3'b000, 2'd2, 1'b1, 32'h12803456, 1);
    load_txn(5'd8,  3'b100, 2'd2, 1'b1, 32'h12803456, 0);
    load_txn(5'd9,  3'b001, 2'd2, 1'b1, 32'h12803456, 2);
    load_txn(5'd10, 3'b010, 2'd0, 1'b1, 32'h12803456, 1);
    load_txn(5'd11, 3'b001, 2'd1, 1'b1, 32'h12803456, 0);
    load_txn(5'd12, 3'b011, 2'd0, 1'b1, 32'h12803456, 0);
    load_txn(5'd13, 3'b010, 2'd0, 1'b1, 32'h12803456, -1);
    load_txn(5'd14, 3'b101, 2'd2, 1'b1, 32'h8000FFFF, TO - 1);
    alu_txn(5'd0, 32'h12345678, 1'b1);
    load_txn(5'd0, 3'b010, 2'd0, 1'b1, 32'hCAFEF00D, 2);
    idle_step(1'b1);

    // Reset while a load is outstanding, then a late response.
    load_txn(5'd15, 3'b010, 2'd0, 1'b1, 32'h0, TO + 10);
    ex_valid     = 1'b1;
    ex_is_load   = 1'b1;
    ex_reg_write = 1'b1;
    ex_rd        = 5'd16;
    ex_funct3    = 3'b010;
    ex_addr_lo   = 2'd0;
    step();
    ex_valid = 1'b0;
    check("rw_pv", 32'(pending_valid), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rw_wen", 32'(wr_enable), 32'd0);
    check("rw_err", 32'(load_err), 32'd0);
    check("rw_addr", 32'(wr_addr), 32'd0);
    check("rw_data", wr_data, 32'd0);
    check_idle_outputs("rw");
    idle_step(1'b1);

    // Randomized mix: back-to-back ALU ops, loads of every type, idle gaps.
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        alu_txn(5'($urandom), $urandom, 1'($urandom_range(0, 4) != 0));
      end else if (kind < 9) begin
        load_txn(5'($urandom), 3'($urandom), 2'($urandom), 1'($urandom_range(0, 4) != 0),
                 $urandom, $urandom_range(0, 7) == 7 ? -1 : $urandom_range(0, TO + 1));
      end else begin
        idle_step(1'($urandom));
      end
    end
    ex_valid = 1'b0;
    idle_step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
